// File: rtl/cdnsdru_usb4_mb_eqt_pkg.sv
// Shared types and helpers for the multi-lane MB EQ-training-complete notifier.
// Also holds the default timeout and retry settings.
package cdnsdru_usb4_mb_eqt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2
   } eqt_state_e;

   localparam int EQT_TIMEOUT_DEF   = 1024;
   localparam int EQT_MAX_RETRY_DEF = 3;

   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdnsdru_usb4_mb_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping. Shared by the MB multi-lane requesters.
module cdnsdru_usb4_mb_rr_arb
   import cdnsdru_usb4_mb_eqt_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = lane_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt,
   output logic         vld
);

   logic [W-1:0] idx_s;

   // Scan from the farthest offset downwards so the nearest requester wins.
   always_comb begin
      gnt   = {W{1'b0}};
      vld   = 1'b0;
      idx_s = {W{1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         idx_s = W'((int'(ptr) + k) % N);
         gnt   = req[idx_s] ? idx_s : gnt;
         vld   = vld | req[idx_s];
      end
   end

endmodule

// File: rtl/cdnsdru_usb4_message_bus_eq_train_mlane.sv
// Multi-lane EQ-training-complete notifier: per-lane pending flags served round-robin
// as priority TX writes, with timeout, bounded retry and drop.
module cdnsdru_usb4_message_bus_eq_train_mlane
   import cdnsdru_usb4_mb_eqt_pkg::*;
#(
   parameter  int NUM_LANES      = 4,
   parameter  int TIMEOUT_CYCLES = EQT_TIMEOUT_DEF,
   parameter  int MAX_RETRY      = EQT_MAX_RETRY_DEF,
   localparam int LANE_W         = lane_w(NUM_LANES)
) (
   input  logic                 pipe_mac2phy_clk,
   input  logic                 pipe_mac2phy_rstn,
   input  logic                 cdb_reset,
   input  logic                 cdb_ctrl_reset,
   input  logic [NUM_LANES-1:0] rx_eq_training_cmpl_stb,
   input  logic                 prio_tx_writes_done_eqt,
   output logic                 rx_eq_training_cmpl_tx_write,
   output logic [LANE_W-1:0]    rx_eq_training_cmpl_lane,
   output logic [NUM_LANES-1:0] eqt_overrun,
   output logic [NUM_LANES-1:0] eqt_drop,
   output logic                 eqt_busy
);

   localparam bit                TMO_EN    = (TIMEOUT_CYCLES > 0);
   localparam int                TMR_W     = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMO_EN ? TMR_W'(TIMEOUT_CYCLES - 1) : {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0]  TMR_MAX   = {TMR_W{1'b1}};
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
   localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

   eqt_state_e             state_r;
   logic [NUM_LANES-1:0]   pend_r;
   logic [LANE_W-1:0]      rr_ptr_r;
   logic [LANE_W-1:0]      cur_lane_r;
   logic [TMR_W-1:0]       timer_r;
   logic [3:0]             retry_r;

   logic [LANE_W-1:0]      arb_gnt_s;
   logic                   arb_vld_s;
   logic                   srst_s;
   logic                   timeout_s;
   logic                   done_hit_s;
   logic                   drop_s;
   logic [NUM_LANES-1:0]   clr_s;
   logic [NUM_LANES-1:0]   pend_nxt_s;
   logic [NUM_LANES-1:0]   ovr_s;
   logic [LANE_W-1:0]      nxt_ptr_s;

   cdnsdru_usb4_mb_rr_arb #(.N(NUM_LANES)) u_arb (
      .req (pend_r),
      .ptr (rr_ptr_r),
      .gnt (arb_gnt_s),
      .vld (arb_vld_s)
   );

   // Clear/set resolution for the pending vector; a same-cycle strobe beats the clear.
   always_comb begin
      srst_s     = cdb_reset | cdb_ctrl_reset;
      timeout_s  = TMO_EN && (timer_r == TMR_LAST);
      done_hit_s = (state_r == WRITE) && prio_tx_writes_done_eqt;
      drop_s     = (state_r == WRITE) && !prio_tx_writes_done_eqt && timeout_s && (retry_r >= RETRY_MAX);
      clr_s      = {NUM_LANES{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
         clr_s[i] = (done_hit_s || drop_s) && (cur_lane_r == LANE_W'(i));
      end
      pend_nxt_s = (pend_r & ~clr_s) | rx_eq_training_cmpl_stb;
      ovr_s      = rx_eq_training_cmpl_stb & pend_r & ~clr_s;
      nxt_ptr_s  = (cur_lane_r == LAST_LANE) ? {LANE_W{1'b0}} : cur_lane_r + LANE_W'(1);
   end

   // Request FSM with pending flags, timer, retry count and sticky status.
   always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
      if (!pipe_mac2phy_rstn) begin
         state_r                      <= IDLE;
         pend_r                       <= {NUM_LANES{1'b0}};
         rr_ptr_r                     <= {LANE_W{1'b0}};
         cur_lane_r                   <= {LANE_W{1'b0}};
         timer_r                      <= {TMR_W{1'b0}};
         retry_r                      <= 4'd0;
         rx_eq_training_cmpl_tx_write <= 1'b0;
         rx_eq_training_cmpl_lane     <= {LANE_W{1'b0}};
         eqt_overrun                  <= {NUM_LANES{1'b0}};
         eqt_drop                     <= {NUM_LANES{1'b0}};
         eqt_busy                     <= 1'b0;
      end else if (srst_s) begin
         state_r                      <= IDLE;
         pend_r                       <= {NUM_LANES{1'b0}};
         rr_ptr_r                     <= {LANE_W{1'b0}};
         cur_lane_r                   <= {LANE_W{1'b0}};
         timer_r                      <= {TMR_W{1'b0}};
         retry_r                      <= 4'd0;
         rx_eq_training_cmpl_tx_write <= 1'b0;
         rx_eq_training_cmpl_lane     <= {LANE_W{1'b0}};
         eqt_overrun                  <= {NUM_LANES{1'b0}};
         eqt_drop                     <= {NUM_LANES{1'b0}};
         eqt_busy                     <= 1'b0;
      end else begin
         pend_r      <= pend_nxt_s;
         eqt_overrun <= eqt_overrun | ovr_s;
         case (state_r)
            IDLE: begin
               if (arb_vld_s) begin
                  state_r                      <= WRITE;
                  cur_lane_r                   <= arb_gnt_s;
                  timer_r                      <= {TMR_W{1'b0}};
                  retry_r                      <= 4'd0;
                  rx_eq_training_cmpl_tx_write <= 1'b1;
                  rx_eq_training_cmpl_lane     <= arb_gnt_s;
                  eqt_busy                     <= 1'b1;
               end else begin
                  eqt_busy <= |pend_nxt_s;
               end
            end
            WRITE: begin
               if (prio_tx_writes_done_eqt) begin
                  state_r                      <= IDLE;
                  rr_ptr_r                     <= nxt_ptr_s;
                  rx_eq_training_cmpl_tx_write <= 1'b0;
                  eqt_busy                     <= |pend_nxt_s;
               end else if (timeout_s) begin
                  rx_eq_training_cmpl_tx_write <= 1'b0;
                  if (retry_r < RETRY_MAX) begin
                     state_r  <= GAP;
                     retry_r  <= retry_r + 4'd1;
                     eqt_busy <= 1'b1;
                  end else begin
                     state_r  <= IDLE;
                     rr_ptr_r <= nxt_ptr_s;
                     eqt_drop <= eqt_drop | clr_s;
                     eqt_busy <= |pend_nxt_s;
                  end
               end else begin
                  timer_r  <= (timer_r != TMR_MAX) ? timer_r + TMR_W'(1) : timer_r;
                  eqt_busy <= 1'b1;
               end
            end
            GAP: begin
               state_r                      <= WRITE;
               timer_r                      <= {TMR_W{1'b0}};
               rx_eq_training_cmpl_tx_write <= 1'b1;
               eqt_busy                     <= 1'b1;
            end
            default: begin
               state_r                      <= IDLE;
               rx_eq_training_cmpl_tx_write <= 1'b0;
               eqt_busy                     <= |pend_nxt_s;
            end
         endcase
      end
   end

endmodule

// File: doc/cdnsdru_usb4_message_bus_eq_train_mlane.md
# cdnsdru_usb4_message_bus_eq_train_mlane

Multi-lane successor to the single-lane EQ-training-complete notifier in the USB4 message bus controller. It collects per-lane `rx_eq_training_cmpl` strobes from the PHY and holds one pending flag per lane. Pending lanes are served one at a time, round-robin, as priority TX write requests towards the MAC, each tagged with its lane index. A write that is not acknowledged in time is retried a bounded number of times, then dropped and flagged. The block sits between the per-lane PHY EQ logic and the MB priority TX write engine.

## Interface
Parameters:
- `NUM_LANES`, 4: number of lanes/channels; range 1..16.
- `TIMEOUT_CYCLES`, 1024: cycles `WRITE` may wait for done before a retry; 0 disables timeout.
- `MAX_RETRY`, 3: retries after the first attempt before a drop; range 0..15.
- Derived: `LANE_W = max(1, clog2(NUM_LANES))`.

Ports:
- `pipe_mac2phy_clk`  in  1  MB clock.
- `pipe_mac2phy_rstn`  in  1  reset, asynchronous, active-low.
- `cdb_reset`  in  1  MB soft reset; synchronous.
- `cdb_ctrl_reset`  in  1  controller soft reset; synchronous, same effect as `cdb_reset`.
- `rx_eq_training_cmpl_stb`  in  NUM_LANES  per-lane EQ-done strobe, one cycle per event.
- `prio_tx_writes_done_eqt`  in  1  MAC write complete for the current request.
- `rx_eq_training_cmpl_tx_write`  out  1  write request level.
- `rx_eq_training_cmpl_lane`  out  LANE_W  lane index of the current request.
- `eqt_overrun`  out  NUM_LANES  sticky: an event was coalesced into an already-pending lane.
- `eqt_drop`  out  NUM_LANES  sticky: the lane was dropped after retries were exhausted.
- `eqt_busy`  out  1  high when any lane is pending or state ≠ `IDLE`.

## Operation
- Pending vector `pend[NUM_LANES]` is set by a strobe and cleared by done for the served lane, or by a drop.
- If set and clear hit the same lane in the same cycle, set wins: the new event stays pending and no overrun is flagged.
- Overrun: a strobe arrives for a lane that is pending and not being cleared that cycle. This includes the in-service lane while it waits for done. Set `eqt_overrun[i]`; the events coalesce into one write.
- FSM states: `IDLE`, `WRITE`, `GAP`.
  - `IDLE`: if `pend` ≠ 0, the arbiter picks the first set bit at or after `rr_ptr`, wrapping. Latch it into `cur_lane`, clear the timer and retry count, go to `WRITE`. Done in `IDLE` is ignored.
  - `WRITE`: `tx_write` = 1 and `lane` = `cur_lane`, both stable. On done: clear `pend[cur_lane]`, set `rr_ptr` = `cur_lane`+1 mod NUM_LANES, go to `IDLE`.
  - Timeout, when `TIMEOUT_CYCLES` > 0 and the timer reaches `TIMEOUT_CYCLES`-1 without done:
    - If retry count < `MAX_RETRY`: increment the count and go to `GAP`.
    - Otherwise: clear `pend[cur_lane]`, set `eqt_drop[cur_lane]`, advance `rr_ptr`, go to `IDLE`.
  - Done has priority over timeout in the same cycle.
  - `GAP`: one cycle with `tx_write` = 0, then back to `WRITE` with the timer cleared and the same lane.
- Timer width is `clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- Reset values, for async reset and for either soft reset, all synchronous clear: `state`=`IDLE`, `pend`=0, `rr_ptr`=0, `cur_lane`=0, timer=0, retry count=0.
  - Outputs: `tx_write`=0, `lane`=0, `eqt_overrun`=0, `eqt_drop`=0, `eqt_busy`=0.
  - A soft reset during `WRITE` drops the request immediately, with no drop flag.
  - A strobe in the same cycle as a soft reset is lost.
- Sticky flags clear only on reset.

## Timing
- All outputs are registered.
- Latency: a strobe in cycle N gives `pend` set in N+1 and `tx_write` high in N+2, when the block was idle.
- `tx_write` falls in the cycle after done is sampled.
- Between back-to-back lanes `tx_write` is low for at least 1 cycle (the `IDLE` cycle).
- Retry: `tx_write` is high for `TIMEOUT_CYCLES` cycles, then low 1 cycle (`GAP`), then high again.
- `lane` changes only while `tx_write` is low.

## Structure
- Package `cdnsdru_usb4_mb_eqt_pkg`: FSM state enum, the `LANE_W` function, and defaults for `TIMEOUT_CYCLES` and `MAX_RETRY`.
- One sub-module, `cdnsdru_usb4_mb_rr_arb`: parameter `N`; inputs are the request vector and start pointer; outputs are grant index and valid. It is combinational and is reused by other MB multi-lane requesters.
- The top level holds the FSM, `pend`, the timer, the retry count and the flags.

## Test plan
- Single event: strobe lane 2 at cycle 10 → `tx_write`=1 and `lane`=2 at cycle 12; done at 15 → `tx_write`=0 at 16, `eqt_busy`=0 at 16.
- Simultaneous strobes on lanes 0, 1 and 3 with `rr_ptr`=0 → writes served in order 0, 1, 3, each followed by a 1-cycle gap. A later strobe on lane 0 after lane 3 completes is served next.
- Overrun: strobe lane 1 twice while lane 1 is in `WRITE` → exactly one write for lane 1 and `eqt_overrun`=4'b0010. A strobe in the same cycle as done → a second write and no overrun.
- Timeout/drop with `TIMEOUT_CYCLES`=8 and `MAX_RETRY`=2, no done → 3 write pulses of 8 cycles, separated by 1-cycle gaps; then `eqt_drop[lane]`=1 and the next pending lane is served.
- Reset mid-operation: `cdb_ctrl_reset` for 1 cycle during `WRITE` with 2 lanes pending → next cycle `tx_write`=0, `pend`=0, flags=0, `eqt_busy`=0. Repeat with async `pipe_mac2phy_rstn` asserted mid-cycle → same values immediately.
- `NUM_LANES`=1 and `TIMEOUT_CYCLES`=0 → behaves as the legacy notifier: no timeout ever, `lane`=0.
